// File: rtl/rnn_mem_pkg.sv
// Shared widths, memory select codes, FSM encoding and beat payload for the
// RNN memory arbiter.
package rnn_mem_pkg;

  localparam int unsigned ADDR_W        = 17;
  localparam int unsigned DATA_W        = 20;
  localparam int unsigned SEL_W         = 3;
  localparam int unsigned MAX_BURST_DEF = 64;

  // Memory select codes
  localparam logic [SEL_W-1:0] SEL_WIH = 3'b000;
  localparam logic [SEL_W-1:0] SEL_BIH = 3'b001;
  localparam logic [SEL_W-1:0] SEL_WHH = 3'b010;
  localparam logic [SEL_W-1:0] SEL_BHH = 3'b011;
  localparam logic [SEL_W-1:0] SEL_HDR = 3'b100;
  localparam logic [SEL_W-1:0] SEL_OUT = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  // One requester beat as presented on its request port
  typedef struct packed {
    logic              we;
    logic              last;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } beat_t;

endpackage

// File: rtl/rnn_rr_pick2.sv
// Two-way round-robin choice.
// Ports: req0/req1 requests, ptr favoured requester on contention,
//        win chosen requester index, any at least one request present.
module rnn_rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic win,
  output logic any
);

  always_comb begin
    any = req0 | req1;
    win = (req0 & req1) ? ptr : req1;
  end

endmodule

// File: rtl/rnn_mem_arbiter.sv
// Arbitrates the single RNN memory port between the compute engine (r0) and
// the writeback/debug engine (r1): round-robin, burst lock, bounded bursts,
// read data routed back to the requester that issued the beat.
// Ports:
//   clk, reset                 clock, async active-high reset
//   rN_req/we/last/sel/addr/wdata  requester N beat request
//   rN_gnt                     requester N owns the port
//   rN_rvalid/rN_rdata         read response, one cycle after the beat
//   rN_err                     one-cycle pulse after an illegal write beat
//   mce/msel/maddr/mdata_w     memory command (zero when no beat issued)
//   mdata_r                    memory read data, cycle after address
//   busy                       grant held or read response pending
import rnn_mem_pkg::*;

module rnn_mem_arbiter #(
  parameter int unsigned      MAX_BURST = MAX_BURST_DEF,
  parameter logic [SEL_W-1:0] OUT_SEL   = SEL_OUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic              r0_last,
  input  logic [SEL_W-1:0]  r0_sel,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic              r1_last,
  input  logic [SEL_W-1:0]  r1_sel,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,
  output logic              mce,
  output logic [SEL_W-1:0]  msel,
  output logic [ADDR_W-1:0] maddr,
  output logic [DATA_W-1:0] mdata_w,
  input  logic [DATA_W-1:0] mdata_r,
  output logic              busy
);

  localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_e       state, state_nxt;
  logic             ptr, ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  beat_t b0, b1, own_beat;
  logic  own_req, other_req, own_id;
  logic  beat, illegal, at_max, rel;
  logic  pick_win, pick_any;
  logic  pend_vld, pend_id;

  assign b0 = '{we: r0_we, last: r0_last, sel: r0_sel, addr: r0_addr, wdata: r0_wdata};
  assign b1 = '{we: r1_we, last: r1_last, sel: r1_sel, addr: r1_addr, wdata: r1_wdata};

  rnn_rr_pick2 u_pick (
    .req0 (r0_req),
    .req1 (r1_req),
    .ptr  (ptr),
    .win  (pick_win),
    .any  (pick_any)
  );

  // Owner view of the request ports and release condition
  always_comb begin
    own_req   = 1'b0;
    other_req = 1'b0;
    own_id    = 1'b0;
    own_beat  = '0;
    case (state)
      ST_OWN0: begin
        own_req   = r0_req;
        other_req = r1_req;
        own_beat  = b0;
      end
      ST_OWN1: begin
        own_req   = r1_req;
        other_req = r0_req;
        own_id    = 1'b1;
        own_beat  = b1;
      end
      default: ;
    endcase
    illegal = own_beat.we & (own_beat.sel != OUT_SEL);
    beat    = own_req;
    at_max  = beat & (cnt == CNT_W'(MAX_BURST - 1));
    rel     = (beat & own_beat.last) | ~own_req | at_max;
  end

  // State, pointer and burst counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      ptr   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: grant from IDLE, handoff / re-grant / idle on release
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_nxt = pick_win ? ST_OWN1 : ST_OWN0;
          cnt_nxt   = '0;
        end
      end
      default: begin
        if (rel) begin
          ptr_nxt = ~own_id;
          cnt_nxt = '0;
          if (other_req)
            state_nxt = own_id ? ST_OWN0 : ST_OWN1;
          else if (at_max & ~own_beat.last)
            state_nxt = state;  // forced release with nobody waiting: keep the port
          else
            state_nxt = ST_IDLE;
        end else if (beat) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  // Outputs: grants from state, memory command follows owner, responses routed
  always_comb begin
    r0_gnt    = (state == ST_OWN0);
    r1_gnt    = (state == ST_OWN1);
    mce       = beat & ~illegal;
    msel      = '0;
    maddr     = '0;
    mdata_w   = '0;
    if (mce) begin
      msel    = own_beat.sel;
      maddr   = own_beat.addr;
      mdata_w = own_beat.wdata;
    end
    r0_rvalid = pend_vld & ~pend_id;
    r1_rvalid = pend_vld & pend_id;
    r0_rdata  = r0_rvalid ? mdata_r : '0;
    r1_rdata  = r1_rvalid ? mdata_r : '0;
    busy      = (state != ST_IDLE) | pend_vld;
  end

  // Pending read response tag and illegal-write pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_vld <= 1'b0;
      pend_id  <= 1'b0;
      r0_err   <= 1'b0;
      r1_err   <= 1'b0;
    end else begin
      pend_vld <= beat & ~own_beat.we;
      pend_id  <= own_id;
      r0_err   <= beat & illegal & ~own_id;
      r1_err   <= beat & illegal & own_id;
    end
  end

endmodule

// File: tb/tb_rnn_mem_arbiter.sv
// Self-checking bench for rnn_mem_arbiter: directed bursts plus a read
// response scoreboard keyed by requester.
import rnn_mem_pkg::*;

module tb_rnn_mem_arbiter;

  logic              clk = 1'b0;
  logic              reset;
  logic              r0_req, r0_we, r0_last;
  logic [SEL_W-1:0]  r0_sel;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_gnt, r0_rvalid, r0_err;
  logic [DATA_W-1:0] r0_rdata;
  logic              r1_req, r1_we, r1_last;
  logic [SEL_W-1:0]  r1_sel;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_gnt, r1_rvalid, r1_err;
  logic [DATA_W-1:0] r1_rdata;
  logic              mce, busy;
  logic [SEL_W-1:0]  msel;
  logic [ADDR_W-1:0] maddr;
  logic [DATA_W-1:0] mdata_w;
  logic [DATA_W-1:0] mdata_r = '0;

  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];

  rnn_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_last(r0_last), .r0_sel(r0_sel),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_gnt(r0_gnt),
    .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_last(r1_last), .r1_sel(r1_sel),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_gnt(r1_gnt),
    .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mce(mce), .msel(msel), .maddr(maddr), .mdata_w(mdata_w),
    .mdata_r(mdata_r), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: returns address + 0x100 the cycle after an issued beat
  always @(posedge clk) mdata_r <= mce ? (DATA_W'(maddr) + DATA_W'('h100)) : '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic req, input logic we, input logic last,
                         input logic [SEL_W-1:0] sel, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wd);
    if (id == 0) begin
      r0_req = req; r0_we = we; r0_last = last; r0_sel = sel; r0_addr = addr; r0_wdata = wd;
    end else begin
      r1_req = req; r1_we = we; r1_last = last; r1_sel = sel; r1_addr = addr; r1_wdata = wd;
    end
  endtask

  function automatic logic gnt_of(input int id);
    return (id == 0) ? r0_gnt : r1_gnt;
  endfunction

  // Holds req for n beats at consecutive addresses from base; called at posedge+1
  task automatic run_burst(input int id, input int n, input logic we, input logic [SEL_W-1:0] sel,
                           input logic [ADDR_W-1:0] base, input logic use_last);
    int b = 0;
    int guard = 0;
    set_req(id, 1'b1, we, use_last && (n == 1), sel, base, '0);
    while (b < n && guard < 400) begin
      @(negedge clk);
      if (gnt_of(id)) b++;
      @(posedge clk);
      #1;
      guard++;
      if (b < n) set_req(id, 1'b1, we, use_last && (b == n - 1), sel, base + ADDR_W'(b), '0);
    end
    set_req(id, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    if (b < n) check($sformatf("burst_timeout_r%0d", id), 32'(b), 32'(n));
  endtask

  // Two simultaneous 2-beat read bursts; 'first' is the expected winner
  task automatic contend(input int first);
    fork
      run_burst(0, 2, 1'b0, SEL_WIH, ADDR_W'('h10), 1'b1);
      run_burst(1, 2, 1'b0, SEL_WHH, ADDR_W'('h20), 1'b1);
      begin
        for (int c = 0; c < 6; c++) begin
          @(negedge clk);
          check($sformatf("cont%0d_r0_gnt_c%0d", first, c), 32'(r0_gnt),
                32'(((c == 1 || c == 2) && first == 0) || ((c == 3 || c == 4) && first == 1)));
          check($sformatf("cont%0d_r1_gnt_c%0d", first, c), 32'(r1_gnt),
                32'(((c == 1 || c == 2) && first == 1) || ((c == 3 || c == 4) && first == 0)));
          if (c == 3) begin
            check("handoff_rvalid_first", 32'((first == 0) ? r0_rvalid : r1_rvalid), 32'(1));
            check("handoff_rvalid_second", 32'((first == 0) ? r1_rvalid : r0_rvalid), 32'(0));
          end
        end
      end
    join
    step();
  endtask

  // Response scoreboard: every read beat expects exactly one rvalid next cycle
  always @(negedge clk) begin
    if (reset) begin
      q0.delete();
      q1.delete();
    end else begin
      if (q0.size() != 0) begin
        check("r0_rvalid", 32'(r0_rvalid), 32'(1));
        check("r0_rdata", 32'(r0_rdata), 32'(q0.pop_front()));
      end else begin
        check("r0_rvalid_quiet", 32'(r0_rvalid), 32'(0));
        check("r0_rdata_quiet", 32'(r0_rdata), 32'(0));
      end
      if (q1.size() != 0) begin
        check("r1_rvalid", 32'(r1_rvalid), 32'(1));
        check("r1_rdata", 32'(r1_rdata), 32'(q1.pop_front()));
      end else begin
        check("r1_rvalid_quiet", 32'(r1_rvalid), 32'(0));
        check("r1_rdata_quiet", 32'(r1_rdata), 32'(0));
      end
      if (r0_req && r0_gnt && !r0_we) q0.push_back(DATA_W'(r0_addr) + DATA_W'('h100));
      if (r1_req && r1_gnt && !r1_we) q1.push_back(DATA_W'(r1_addr) + DATA_W'('h100));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    set_req(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    check("rst_r0_gnt", 32'(r0_gnt), 32'(0));
    check("rst_r1_gnt", 32'(r1_gnt), 32'(0));
    check("rst_mce", 32'(mce), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    step();
    reset = 1'b0;
    step();

    // Contention after reset: r0 first, r1 without a bubble
    contend(0);

    // Single 4-beat read burst by r0
    fork
      run_burst(0, 4, 1'b0, SEL_WIH, ADDR_W'(0), 1'b1);
      begin
        @(negedge clk);
        check("sb_gnt_req_cycle", 32'(r0_gnt), 32'(0));
        check("sb_mce_req_cycle", 32'(mce), 32'(0));
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          check("sb_gnt", 32'(r0_gnt), 32'(1));
          check("sb_mce", 32'(mce), 32'(1));
          check("sb_maddr", 32'(maddr), 32'(c));
          check("sb_msel", 32'(msel), 32'(SEL_WIH));
        end
        @(negedge clk);
        check("sb_released", 32'(r0_gnt), 32'(0));
        check("sb_mce_off", 32'(mce), 32'(0));
        check("sb_busy_pending", 32'(busy), 32'(1));
        @(negedge clk);
        check("sb_busy_idle", 32'(busy), 32'(0));
      end
    join
    step();

    // Pointer now favours r1
    contend(1);

    // Illegal write by r1
    set_req(1, 1'b1, 1'b1, 1'b1, SEL_WHH, ADDR_W'('h33), DATA_W'('h12345));
    @(negedge clk);
    check("ilw_gnt_req_cycle", 32'(r1_gnt), 32'(0));
    step();
    @(negedge clk);
    check("ilw_gnt", 32'(r1_gnt), 32'(1));
    check("ilw_mce", 32'(mce), 32'(0));
    check("ilw_mdata_w", 32'(mdata_w), 32'(0));
    check("ilw_err_early", 32'(r1_err), 32'(0));
    step();
    set_req(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    check("ilw_err_pulse", 32'(r1_err), 32'(1));
    check("ilw_r0_err", 32'(r0_err), 32'(0));
    check("ilw_released", 32'(r1_gnt), 32'(0));
    step();
    @(negedge clk);
    check("ilw_err_clear", 32'(r1_err), 32'(0));
    step();

    // Legal write to the output memory
    set_req(1, 1'b1, 1'b1, 1'b1, SEL_OUT, ADDR_W'('h40), DATA_W'('h0abcd));
    @(negedge clk);
    step();
    @(negedge clk);
    check("wr_mce", 32'(mce), 32'(1));
    check("wr_msel", 32'(msel), 32'(SEL_OUT));
    check("wr_maddr", 32'(maddr), 32'('h40));
    check("wr_mdata_w", 32'(mdata_w), 32'('h0abcd));
    step();
    set_req(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    check("wr_no_err", 32'(r1_err), 32'(0));
    step();

    // MAX_BURST forced release with r1 waiting
    fork
      run_burst(0, 70, 1'b0, SEL_WIH, ADDR_W'('h1000), 1'b0);
      run_burst(1, 1, 1'b0, SEL_BHH, ADDR_W'('h2000), 1'b1);
      begin
        int nb = 0;
        int g = 0;
        while (!r0_gnt && g < 10) begin
          @(negedge clk);
          g++;
        end
        while (r0_gnt && nb < 100) begin
          nb++;
          @(negedge clk);
        end
        check("max_burst_len", 32'(nb), 32'(64));
        check("max_handoff_r1", 32'(r1_gnt), 32'(1));
        @(negedge clk);
        check("max_regrant_r0", 32'(r0_gnt), 32'(1));
      end
    join
    step();

    // MAX_BURST with nobody waiting: grant held across the boundary
    fork
      run_burst(0, 70, 1'b0, SEL_WIH, ADDR_W'('h3000), 1'b0);
      begin
        int nb = 0;
        int g = 0;
        while (!r0_gnt && g < 10) begin
          @(negedge clk);
          g++;
        end
        while (r0_gnt && mce && nb < 100) begin
          nb++;
          @(negedge clk);
        end
        check("stream70_beats", 32'(nb), 32'(70));
      end
    join
    step();

    // Move pointer to r1 before the reset test
    run_burst(0, 1, 1'b0, SEL_HDR, ADDR_W'('h50), 1'b1);
    step();

    // Async reset during beat 2 of an r0 read burst
    set_req(0, 1'b1, 1'b0, 1'b0, SEL_HDR, ADDR_W'('h200), '0);
    @(negedge clk);
    step();
    @(negedge clk);
    check("rb_beat1_gnt", 32'(r0_gnt), 32'(1));
    step();
    set_req(0, 1'b1, 1'b0, 1'b0, SEL_HDR, ADDR_W'('h201), '0);
    @(negedge clk);
    check("rb_beat2_mce", 32'(mce), 32'(1));
    #2;
    reset = 1'b1;
    #1;
    check("ar_r0_gnt", 32'(r0_gnt), 32'(0));
    check("ar_r1_gnt", 32'(r1_gnt), 32'(0));
    check("ar_mce", 32'(mce), 32'(0));
    check("ar_msel", 32'(msel), 32'(0));
    check("ar_maddr", 32'(maddr), 32'(0));
    check("ar_r0_rvalid", 32'(r0_rvalid), 32'(0));
    check("ar_r0_rdata", 32'(r0_rdata), 32'(0));
    check("ar_busy", 32'(busy), 32'(0));
    check("ar_r0_err", 32'(r0_err), 32'(0));
    set_req(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step();
    step();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'(0));
    end
    step();
    contend(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
